seg7_readback: RTL and testbench

SEG7_READBACK -- requirements
Module: seg7_readback

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seg7_pattern_lookup.sv | 58 +++++
 rtl/seg7_readback.sv | 128 ++++++++++++
 tb/tb_seg7_readback.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and FSM state type for the readback path.
// Segment order is {a,b,c,d,e,f,g} with a at the MSB; 1 means lit.
package seg7_pkg;

  localparam logic [6:0] SegBlank = 7'b0000000;

  localparam logic [6:0] Seg0 = 7'b1111110;
  localparam logic [6:0] Seg1 = 7'b0110000;
  localparam logic [6:0] Seg2 = 7'b1101101;
  localparam logic [6:0] Seg3 = 7'b1111001;
  localparam logic [6:0] Seg4 = 7'b0110011;
  localparam logic [6:0] Seg5 = 7'b1011011;
  localparam logic [6:0] Seg6 = 7'b1011111;
  localparam logic [6:0] Seg7 = 7'b1110000;
  localparam logic [6:0] Seg8 = 7'b1111111;
  localparam logic [6:0] Seg9 = 7'b1111011;
  localparam logic [6:0] SegA = 7'b1110111;
  localparam logic [6:0] SegB = 7'b0011111;
  localparam logic [6:0] SegC = 7'b1001110;
  localparam logic [6:0] SegD = 7'b0111101;
  localparam logic [6:0] SegE = 7'b1001111;
  localparam logic [6:0] SegF = 7'b1000111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLocked
  } state_e;

  // Forward decoder (digit to segments), used by display drivers that share this table.
  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    logic [6:0] pat;
    pat = SegBlank;
    unique case (code)
      4'h0: pat = Seg0;
      4'h1: pat = Seg1;
      4'h2: pat = Seg2;
      4'h3: pat = Seg3;
      4'h4: pat = Seg4;
      4'h5: pat = Seg5;
      4'h6: pat = Seg6;
      4'h7: pat = Seg7;
      4'h8: pat = Seg8;
      4'h9: pat = Seg9;
      4'hA: pat = SegA;
      4'hB: pat = SegB;
      4'hC: pat = SegC;
      4'hD: pat = SegD;
      4'hE: pat = SegE;
      4'hF: pat = SegF;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup: segment pattern to digit code.
// is_legal flags any of the 16 digit glyphs; hex-mode gating is left to the caller.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       is_hex,
  output logic       is_legal,
  output logic       is_blank
);

  // Match the pattern against every glyph; unknown patterns fall to the default.
  always_comb begin
    code     = 4'h0;
    is_hex   = 1'b0;
    is_legal = 1'b1;
    is_blank = (seg == SegBlank);
    case (seg)
      Seg0: code = 4'h0;
      Seg1: code = 4'h1;
      Seg2: code = 4'h2;
      Seg3: code = 4'h3;
      Seg4: code = 4'h4;
      Seg5: code = 4'h5;
      Seg6: code = 4'h6;
      Seg7: code = 4'h7;
      Seg8: code = 4'h8;
      Seg9: code = 4'h9;
      SegA: begin
        code   = 4'hA;
        is_hex = 1'b1;
      end
      SegB: begin
        code   = 4'hB;
        is_hex = 1'b1;
      end
      SegC: begin
        code   = 4'hC;
        is_hex = 1'b1;
      end
      SegD: begin
        code   = 4'hD;
        is_hex = 1'b1;
      end
      SegE: begin
        code   = 4'hE;
        is_hex = 1'b1;
      end
      SegF: begin
        code   = 4'hF;
        is_hex = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Seven-segment readback: samples the segment lines, waits for STABLE_CYCLES identical
// samples, then decodes the settled pattern once into a digit, an error or a blank flag.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hex_mode,
  input  logic [6:0] seg,
  output logic [3:0] data,
  output logic       valid,
  output logic       err,
  output logic       blank
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Input sample stage and its one-cycle-old copy used for the stability compare.
  logic [6:0] seg_q, prev_seg_q;
  logic       hex_q, prev_hex_q;
  // Low only for the first edge after reset so that edge just loads the sample stage.
  logic       started_q;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      data_q;
  logic            valid_q, err_q, blank_q;

  logic [3:0]      lk_code;
  logic            lk_is_hex, lk_is_legal, lk_is_blank;
  logic            same;
  logic            accept;
  logic [CntW-1:0] cnt_inc;

  seg7_pattern_lookup u_lookup (
    .seg      (seg_q),
    .code     (lk_code),
    .is_hex   (lk_is_hex),
    .is_legal (lk_is_legal),
    .is_blank (lk_is_blank)
  );

  // Stability compare, saturating count and hex-mode legality of the sampled pattern.
  always_comb begin
    same    = (seg_q == prev_seg_q) && (hex_q == prev_hex_q);
    cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
    accept  = lk_is_legal && (!lk_is_hex || hex_q);
  end

  // Sample stage plus settle/lock FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= SegBlank;
      prev_seg_q <= SegBlank;
      hex_q      <= 1'b0;
      prev_hex_q <= 1'b0;
      started_q  <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_q     <= 4'h0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      seg_q      <= seg;
      hex_q      <= hex_mode;
      prev_seg_q <= seg_q;
      prev_hex_q <= hex_q;
      started_q  <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;

      if (!en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        blank_q <= 1'b0;
      end else if (started_q) begin
        case (state_q)
          StIdle: begin
            state_q <= StSettle;
            cnt_q   <= CntOne;
          end
          StSettle: begin
            if (!same) begin
              cnt_q <= CntOne;
            end else if (cnt_inc == CntMax) begin
              // Pattern has settled: evaluate it exactly once on entry to LOCKED.
              state_q <= StLocked;
              cnt_q   <= CntMax;
              if (lk_is_blank) begin
                blank_q <= 1'b1;
              end else if (accept) begin
                data_q  <= lk_code;
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StLocked: begin
            if (!same) begin
              state_q <= StSettle;
              cnt_q   <= CntOne;
              blank_q <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback with STABLE_CYCLES = 4.
module tb_seg7_readback;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       hex_mode;
  logic [6:0] seg;
  logic [3:0] data;
  logic       valid;
  logic       err;
  logic       blank;

  int checks = 0;
  int errors = 0;

  seg7_readback #(
    .STABLE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hex_mode (hex_mode),
    .seg      (seg),
    .data     (data),
    .valid    (valid),
    .err      (err),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hex;
    logic [6:0] pat;
    int         nv;
    int         ne;
    logic       blk;
    logic [3:0] dat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nv;
    int ne;
    int both;

    // {hex_mode, seg, valid pulses, err pulses, blank, data} per held pattern.
    vecs[0]  = '{1'b0, 7'b1111110, 1, 0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 7'b1011011, 1, 0, 1'b0, 4'h5};
    vecs[2]  = '{1'b0, 7'b1110111, 0, 1, 1'b0, 4'h5};
    vecs[3]  = '{1'b1, 7'b1110111, 1, 0, 1'b0, 4'hA};
    vecs[4]  = '{1'b1, 7'b0011111, 1, 0, 1'b0, 4'hB};
    vecs[5]  = '{1'b0, 7'b0011111, 0, 1, 1'b0, 4'hB};
    vecs[6]  = '{1'b1, 7'b1001110, 1, 0, 1'b0, 4'hC};
    vecs[7]  = '{1'b1, 7'b0111101, 1, 0, 1'b0, 4'hD};
    vecs[8]  = '{1'b1, 7'b1001111, 1, 0, 1'b0, 4'hE};
    vecs[9]  = '{1'b1, 7'b1000111, 1, 0, 1'b0, 4'hF};
    vecs[10] = '{1'b0, 7'b1111111, 1, 0, 1'b0, 4'h8};
    vecs[11] = '{1'b0, 7'b0000000, 0, 0, 1'b1, 4'h8};
    vecs[12] = '{1'b0, 7'b0110000, 1, 0, 1'b0, 4'h1};
    vecs[13] = '{1'b0, 7'b1010101, 0, 1, 1'b0, 4'h1};
    vecs[14] = '{1'b1, 7'b1101101, 1, 0, 1'b0, 4'h2};
    vecs[15] = '{1'b0, 7'b1111001, 1, 0, 1'b0, 4'h3};
    vecs[16] = '{1'b0, 7'b0110011, 1, 0, 1'b0, 4'h4};
    vecs[17] = '{1'b0, 7'b1011111, 1, 0, 1'b0, 4'h6};
    vecs[18] = '{1'b0, 7'b1110000, 1, 0, 1'b0, 4'h7};
    vecs[19] = '{1'b1, 7'b1111011, 1, 0, 1'b0, 4'h9};

    // Reset values, then latency from the first sampling edge after reset release.
    rst_n    = 1'b0;
    en       = 1'b1;
    hex_mode = 1'b0;
    seg      = 7'b1011011;
    tick();
    tick();
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_blank", int'(blank), 0);
    rst_n = 1'b1;
    // Edge 1 is the first sampling edge; valid shows after edge 5.
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("lat_valid_e%0d", i), int'(valid), (i == 5) ? 1 : 0);
      check($sformatf("lat_err_e%0d", i), int'(err), 0);
    end
    check("lat_data", int'(data), 5);

    // Table: hold each pattern 8 cycles, count pulses, then check levels.
    for (int v = 0; v < 20; v++) begin
      hex_mode = vecs[v].hex;
      seg      = vecs[v].pat;
      nv   = 0;
      ne   = 0;
      both = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (valid) nv++;
        if (err) ne++;
        if (valid && err) both = 1;
      end
      check($sformatf("v%0d_valid_cnt", v), nv, vecs[v].nv);
      check($sformatf("v%0d_err_cnt", v), ne, vecs[v].ne);
      check($sformatf("v%0d_excl", v), both, 0);
      check($sformatf("v%0d_blank", v), int'(blank), int'(vecs[v].blk));
      check($sformatf("v%0d_data", v), int'(data), int'(vecs[v].dat));
    end

    // Reset mid-settle: immediate clear, then a full restabilization.
    hex_mode = 1'b0;
    seg      = 7'b0110011;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_blank", int'(blank), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("rst_resettle_e%0d", i), int'(valid), (i == 5) ? 1 : 0);
    end
    check("rst_resettle_data", int'(data), 4);

    // en dropped while locked on 9, then raised with the same pattern.
    seg = 7'b1111011;
    for (int i = 0; i < 8; i++) tick();
    check("en_lock_data", int'(data), 9);
    en = 1'b0;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid || err) nv++;
    end
    check("en_off_pulses", nv, 0);
    check("en_off_data", int'(data), 9);
    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("en_on_valid_e%0d", i), int'(valid), (i == 4) ? 1 : 0);
    end
    check("en_on_data", int'(data), 9);

    // One-sample glitch inside a settle must restart the count.
    seg = 7'b1111110;
    nv  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid || err) nv++;
    end
    seg = 7'b1111111;
    tick();
    if (valid || err) nv++;
    check("glitch_pre_pulses", nv, 0);
    seg = 7'b1111110;
    ne  = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (err) ne++;
      check($sformatf("glitch_valid_e%0d", i), int'(valid), (i == 5) ? 1 : 0);
    end
    check("glitch_err", ne, 0);
    check("glitch_data", int'(data), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
